// File: rtl/md_issue_ctrl_if.sv
// Bus between md_issue_ctrl and its neighbours: the pipeline side (request,
// stall, result) and the HI/LO unit side (OP/A/B, busy, HI/LO).
// MD_SHADOW_CHECK_EN adds the sticky md_err flag.
interface md_issue_ctrl_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        divz;
`ifdef MD_SHADOW_CHECK_EN
    logic        md_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, md_busy, md_hi, md_lo,
        output md_op, md_a, md_b, stall, rd_data, rd_valid, divz, md_err
    );
    modport master (
        output req_valid, req_op, req_a, req_b, md_busy, md_hi, md_lo,
        input  md_op, md_a, md_b, stall, rd_data, rd_valid, divz, md_err
    );
`else
    modport slave (
        input  req_valid, req_op, req_a, req_b, md_busy, md_hi, md_lo,
        output md_op, md_a, md_b, stall, rd_data, rd_valid, divz
    );
    modport master (
        output req_valid, req_op, req_a, req_b, md_busy, md_hi, md_lo,
        input  md_op, md_a, md_b, stall, rd_data, rd_valid, divz
    );
`endif
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage requester for the multiply/divide unit: issues md ops on the
// OP/A/B bus, shadows the unit latency to stall the pipeline, returns HI/LO
// for mfhi/mflo and drops divide-by-zero.
// Optional macro MD_SHADOW_CHECK_EN: sticky md_err on shadow/busy mismatch.
module md_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CNT_W      = 4
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             divz_q, divz_d;

    logic op_valid, is_mul, is_div, is_mt, is_mf, div_zero, stall_c, issue;

    // Request decode; every term is gated by reset so outputs read 0 in reset
    always_comb begin
        op_valid = reset && bus.req_valid && (bus.req_op >= 4'd1) && (bus.req_op <= 4'd8);
        is_mul   = op_valid && ((bus.req_op == 4'd1) || (bus.req_op == 4'd2));
        is_div   = op_valid && ((bus.req_op == 4'd3) || (bus.req_op == 4'd4));
        is_mt    = op_valid && ((bus.req_op == 4'd5) || (bus.req_op == 4'd6));
        is_mf    = op_valid && ((bus.req_op == 4'd7) || (bus.req_op == 4'd8));
        div_zero = is_div && (bus.req_b == '0);
        stall_c  = op_valid && ((state_q == BUSY) || bus.md_busy);
        issue    = !stall_c && (is_mul || is_mt || (is_div && !div_zero));
    end

    // Outputs towards the unit and the E-stage result mux
    always_comb begin
        bus.md_op    = issue ? bus.req_op : '0;
        bus.md_a     = reset ? bus.req_a : '0;
        bus.md_b     = reset ? bus.req_b : '0;
        bus.stall    = stall_c;
        bus.rd_valid = is_mf && !stall_c;
        bus.rd_data  = '0;
        if (is_mf && !stall_c) begin
            bus.rd_data = (bus.req_op == 4'd7) ? bus.md_hi : bus.md_lo;
        end
        bus.divz     = divz_q;
    end

    // Shadow counter next state: load on issue, count down to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        divz_d  = div_zero && !stall_c;
        case (state_q)
            IDLE: begin
                if (issue && is_mul) begin
                    state_d = BUSY;
                    cnt_d   = MUL_N;
                end else if (issue && is_div) begin
                    state_d = BUSY;
                    cnt_d   = DIV_N;
                end
            end
            BUSY: begin
                if (cnt_q <= ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and divide-by-zero pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divz_q  <= divz_d;
        end
    end

`ifdef MD_SHADOW_CHECK_EN
    logic             err_q, err_d;
    logic             div_kind_q, div_kind_d;
    logic             idle_busy_q, idle_busy_d;
    logic [CNT_W-1:0] early_lim;

    // Mismatch detection: unit idle too early in BUSY, or busy two IDLE cycles running
    always_comb begin
        div_kind_d  = (issue && (state_q == IDLE)) ? is_div : div_kind_q;
        early_lim   = div_kind_q ? (DIV_N - ONE) : (MUL_N - ONE);
        idle_busy_d = (state_q == IDLE) && bus.md_busy;
        err_d       = err_q;
        if ((state_q == BUSY) && (cnt_q < early_lim) && !bus.md_busy) begin
            err_d = 1'b1;
        end
        if (idle_busy_q && idle_busy_d) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q       <= 1'b0;
            div_kind_q  <= 1'b0;
            idle_busy_q <= 1'b0;
        end else begin
            err_q       <= err_d;
            div_kind_q  <= div_kind_d;
            idle_busy_q <= idle_busy_d;
        end
    end

    assign bus.md_err = err_q;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural HI/LO unit model.
module tb_md_issue_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cmps = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    md_issue_ctrl_if bus ();

    md_issue_ctrl #(
        .MUL_CYCLES(5),
        .DIV_CYCLES(10),
        .CNT_W(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural HI/LO unit: result lands on the edge its busy count ends
    logic [3:0]  ucnt;
    logic [31:0] uhi, ulo, phi, plo;
    logic        uoff = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ucnt <= '0;
            uhi  <= '0;
            ulo  <= '0;
            phi  <= '0;
            plo  <= '0;
        end else if (ucnt != 4'd0) begin
            ucnt <= ucnt - 4'd1;
            if (ucnt == 4'd1) begin
                uhi <= phi;
                ulo <= plo;
            end
        end else begin
            case (bus.md_op)
                4'd1: begin
                    {phi, plo} <= 64'($signed({{32{bus.md_a[31]}}, bus.md_a}) *
                                      $signed({{32{bus.md_b[31]}}, bus.md_b}));
                    ucnt <= 4'd5;
                end
                4'd2: begin
                    {phi, plo} <= {32'd0, bus.md_a} * {32'd0, bus.md_b};
                    ucnt <= 4'd5;
                end
                4'd3: begin
                    plo  <= 32'($signed(bus.md_a) / $signed(bus.md_b));
                    phi  <= 32'($signed(bus.md_a) % $signed(bus.md_b));
                    ucnt <= 4'd10;
                end
                4'd4: begin
                    plo  <= bus.md_a / bus.md_b;
                    phi  <= bus.md_a % bus.md_b;
                    ucnt <= 4'd10;
                end
                4'd5: uhi <= bus.md_a;
                4'd6: ulo <= bus.md_a;
                default: ;
            endcase
        end
    end

    assign bus.md_busy = (ucnt != 4'd0) && !uoff;
    assign bus.md_hi   = uhi;
    assign bus.md_lo   = ulo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // New request just after the edge, then settle to the sampling point
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clk);
    endtask

    task automatic hold();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd1;
        bus.req_a     = 32'hFFFF_FFFE;
        bus.req_b     = 32'd3;
        #2;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_md_op", 32'(bus.md_op), 32'd0);
        chk("rst_md_a", bus.md_a, 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_divz", 32'(bus.divz), 32'd0);
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // mult -2 * 3
        step(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_md_op", 32'(bus.md_op), 32'd1);
        chk("mult_stall", 32'(bus.stall), 32'd0);
        chk("mult_md_a", bus.md_a, 32'hFFFF_FFFE);
        chk("mult_md_b", bus.md_b, 32'd3);
        step(1'b1, 4'd8, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("mult_win_stall", 32'(bus.stall), 32'd1);
            chk("mult_win_rdv", 32'(bus.rd_valid), 32'd0);
            chk("mult_win_md_op", 32'(bus.md_op), 32'd0);
            hold();
        end
        chk("mflo_stall", 32'(bus.stall), 32'd0);
        chk("mflo_rdv", 32'(bus.rd_valid), 32'd1);
        chk("mflo_data", bus.rd_data, 32'hFFFF_FFFA);
        step(1'b1, 4'd7, 32'd0, 32'd0);
        chk("mfhi_data", bus.rd_data, 32'hFFFF_FFFF);

        // divu 100 / 7
        step(1'b1, 4'd4, 32'd100, 32'd7);
        chk("divu_md_op", 32'(bus.md_op), 32'd4);
        step(1'b1, 4'd8, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("divu_win_stall", 32'(bus.stall), 32'd1);
            hold();
        end
        chk("divu_lo", bus.rd_data, 32'd14);
        step(1'b1, 4'd7, 32'd0, 32'd0);
        chk("divu_hi", bus.rd_data, 32'd2);

        // back-to-back divu: second held off for the full window
        step(1'b1, 4'd4, 32'd50, 32'd5);
        chk("b2b_first_md_op", 32'(bus.md_op), 32'd4);
        step(1'b1, 4'd4, 32'd9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk("b2b_stall", 32'(bus.stall), 32'd1);
            chk("b2b_md_op", 32'(bus.md_op), 32'd0);
            hold();
        end
        chk("b2b_issue_stall", 32'(bus.stall), 32'd0);
        chk("b2b_issue_md_op", 32'(bus.md_op), 32'd4);

        // non-md requests during BUSY are ignored
        step(1'b1, 4'd9, 32'd1, 32'd1);
        chk("op9_stall", 32'(bus.stall), 32'd0);
        chk("op9_md_op", 32'(bus.md_op), 32'd0);
        step(1'b1, 4'd0, 32'd1, 32'd1);
        chk("op0_stall", 32'(bus.stall), 32'd0);
        step(1'b0, 4'd1, 32'd1, 32'd1);
        chk("novalid_stall", 32'(bus.stall), 32'd0);
        chk("novalid_md_op", 32'(bus.md_op), 32'd0);
        step(1'b1, 4'd8, 32'd0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            chk("b2b_mflo_stall", 32'(bus.stall), 32'd1);
            hold();
        end
        chk("b2b_lo", bus.rd_data, 32'd4);
        step(1'b1, 4'd7, 32'd0, 32'd0);
        chk("b2b_hi", bus.rd_data, 32'd1);

        // divide by zero is dropped with a delayed divz pulse
        step(1'b1, 4'd3, 32'd5, 32'd0);
        chk("divz_md_op", 32'(bus.md_op), 32'd0);
        chk("divz_stall", 32'(bus.stall), 32'd0);
        chk("divz_same_cycle", 32'(bus.divz), 32'd0);
        step(1'b1, 4'd8, 32'd0, 32'd0);
        chk("divz_pulse", 32'(bus.divz), 32'd1);
        chk("divz_lo_kept", bus.rd_data, 32'd4);
        step(1'b1, 4'd7, 32'd0, 32'd0);
        chk("divz_pulse_end", 32'(bus.divz), 32'd0);
        chk("divz_hi_kept", bus.rd_data, 32'd1);

        // mthi then mfhi
        step(1'b1, 4'd5, 32'h1234_5678, 32'd0);
        chk("mthi_md_op", 32'(bus.md_op), 32'd5);
        chk("mthi_stall", 32'(bus.stall), 32'd0);
        step(1'b1, 4'd7, 32'd0, 32'd0);
        chk("mthi_mfhi_stall", 32'(bus.stall), 32'd0);
        chk("mthi_mfhi_rdv", 32'(bus.rd_valid), 32'd1);
        chk("mthi_mfhi_data", bus.rd_data, 32'h1234_5678);

        // mtlo during BUSY waits for IDLE
        step(1'b1, 4'd1, 32'd2, 32'd3);
        chk("mult2_md_op", 32'(bus.md_op), 32'd1);
        step(1'b1, 4'd6, 32'h0000_AAAA, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("mtlo_stall", 32'(bus.stall), 32'd1);
            chk("mtlo_md_op", 32'(bus.md_op), 32'd0);
            hold();
        end
        chk("mtlo_issue", 32'(bus.md_op), 32'd6);
        step(1'b1, 4'd8, 32'd0, 32'd0);
        chk("mtlo_lo", bus.rd_data, 32'h0000_AAAA);
        step(1'b1, 4'd7, 32'd0, 32'd0);
        chk("mult2_hi", bus.rd_data, 32'd0);

        // reset in the middle of a div
        step(1'b1, 4'd3, 32'd20, 32'd3);
        chk("rdiv_md_op", 32'(bus.md_op), 32'd3);
        step(1'b0, 4'd0, 32'd0, 32'd0);
        hold();
        step(1'b1, 4'd8, 32'd0, 32'd0);
        chk("rdiv_stall_before", 32'(bus.stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rdiv_stall", 32'(bus.stall), 32'd0);
        chk("rdiv_md_op_rst", 32'(bus.md_op), 32'd0);
        chk("rdiv_divz", 32'(bus.divz), 32'd0);
        chk("rdiv_cnt", 32'(dut.cnt_q), 32'd0);
        chk("rdiv_rdv", 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        step(1'b1, 4'd1, 32'd7, 32'd6);
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        chk("post_rst_md_op", 32'(bus.md_op), 32'd1);
        step(1'b1, 4'd8, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_win", 32'(bus.stall), 32'd1);
            hold();
        end
        chk("post_rst_lo", bus.rd_data, 32'd42);

`ifdef MD_SHADOW_CHECK_EN
        chk("err_clear", 32'(bus.md_err), 32'd0);
        step(1'b1, 4'd1, 32'd1, 32'd1);
        step(1'b0, 4'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        uoff = 1'b1;
        @(negedge clk);
        hold();
        hold();
        chk("err_set", 32'(bus.md_err), 32'd1);
        hold();
        hold();
        uoff = 1'b0;
        hold();
        hold();
        chk("err_sticky", 32'(bus.md_err), 32'd1);
        reset = 1'b0;
        #1;
        chk("err_reset", 32'(bus.md_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
